// File: rtl/uart_cmd_responder_if.sv
// Byte and register-bus signals between the UART command responder and its surroundings.
// master is the responder's view of the bundle; slave is the view of the UART/register side.
interface uart_cmd_responder_if;
    logic       Rx_valid;
    logic [7:0] rx_data;
    logic       tx_active;
    logic       tx_done;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       cmd_error;

    modport master (
        input  Rx_valid, rx_data, tx_active, tx_done, reg_rdata,
        output tx_dv, tx_byte, reg_addr, reg_wdata, reg_we, reg_rd, cmd_error
    );

    modport slave (
        output Rx_valid, rx_data, tx_active, tx_done, reg_rdata,
        input  tx_dv, tx_byte, reg_addr, reg_wdata, reg_we, reg_rd, cmd_error
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// Decodes 'W' addr data / 'R' addr commands from UART bytes, performs one register access
// and returns a one-byte reply ('K', the read value, or '?').
module uart_cmd_responder #(
    parameter int CLKS_PER_TIMEOUT = 5_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_cmd_responder_if.master  bus
);

    localparam int         TW       = $clog2(CLKS_PER_TIMEOUT);
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RPL_OK   = 8'h4B;
    localparam logic [7:0] RPL_BAD  = 8'h3F;

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, WRITE, READ, READ_CAP, SEND, WAIT_TX
    } state_t;

    state_t        state;
    logic          is_write;
    logic [TW-1:0] timer;
    logic          tx_dv_q;
    logic [7:0]    tx_byte_q;
    logic [7:0]    reg_addr_q;
    logic [7:0]    reg_wdata_q;
    logic          reg_we_q;
    logic          reg_rd_q;
    logic          cmd_error_q;

    assign bus.tx_dv     = tx_dv_q;
    assign bus.tx_byte   = tx_byte_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_rd    = reg_rd_q;
    assign bus.cmd_error = cmd_error_q;

    // NOTE: all state lives in one clocked block with non-blocking assignments, so every
    // right-hand side reads the pre-edge value and later assignments in the block win.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            is_write    <= 1'b0;
            timer       <= '0;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= 8'h00;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            cmd_error_q <= 1'b0;
        end else begin
            tx_dv_q     <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            cmd_error_q <= 1'b0;
            timer       <= '0;

            case (state)
                IDLE: begin
                    if (bus.Rx_valid) begin
                        if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
                            is_write <= (bus.rx_data == OP_WRITE);
                            state    <= GET_ADDR;
                        end else begin
                            tx_byte_q   <= RPL_BAD;
                            cmd_error_q <= 1'b1;
                            state       <= SEND;
                        end
                    end
                end

                GET_ADDR: begin
                    if (bus.Rx_valid) begin
                        reg_addr_q <= bus.rx_data;
                        state      <= is_write ? GET_DATA : READ;
                    end else if (timer == TW'(CLKS_PER_TIMEOUT - 1)) begin
                        cmd_error_q <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                GET_DATA: begin
                    if (bus.Rx_valid) begin
                        reg_wdata_q <= bus.rx_data;
                        state       <= WRITE;
                    end else if (timer == TW'(CLKS_PER_TIMEOUT - 1)) begin
                        cmd_error_q <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                WRITE: begin
                    reg_we_q  <= 1'b1;
                    tx_byte_q <= RPL_OK;
                    state     <= SEND;
                end

                READ: begin
                    reg_rd_q <= 1'b1;
                    state    <= READ_CAP;
                end

                // The strobe is still high on the first READ_CAP cycle; read data is valid one cycle later.
                READ_CAP: begin
                    if (!reg_rd_q) begin
                        tx_byte_q <= bus.reg_rdata;
                        state     <= SEND;
                    end
                end

                SEND: begin
                    if (!bus.tx_active) begin
                        tx_dv_q <= 1'b1;
                        state   <= WAIT_TX;
                    end
                end

                WAIT_TX: begin
                    if (bus.tx_done) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase

            // Bytes arriving while a command is being executed or answered are discarded.
            if (bus.Rx_valid && !(state inside {IDLE, GET_ADDR, GET_DATA})) begin
                cmd_error_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: stimulus pushes expected bus accesses, replies
// and errors into queues; a monitor pops and compares whenever the DUT strobes an output.
module tb_uart_cmd_responder;

    localparam int CLKS_PER_TIMEOUT = 100;
    localparam int TX_BUSY_CYCLES   = 8;

    typedef struct packed {
        logic       is_write;
        logic [7:0] addr;
        logic [7:0] data;
    } bus_ev_t;

    logic clk = 1'b0;
    logic rst;
    logic tx_busy   = 1'b0;
    logic hold_busy = 1'b0;

    always #5 clk = ~clk;

    uart_cmd_responder_if bus ();

    uart_cmd_responder #(.CLKS_PER_TIMEOUT(CLKS_PER_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.tx_active = tx_busy | hold_busy;

    int tests = 0;
    int fails = 0;
    int n_err = 0, n_we = 0, n_rd = 0, n_txdv = 0;

    bus_ev_t    bus_q[$];
    logic [7:0] tx_q[$];
    int         err_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rom(input logic [7:0] a);
        case (a)
            8'h12:   return 8'h3C;
            8'h20:   return 8'hC3;
            default: return ~a;
        endcase
    endfunction

    // Register bus: read data appears the cycle after reg_rd and then holds.
    initial begin
        logic [7:0] a;
        bus.reg_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.reg_rd === 1'b1) begin
                a = bus.reg_addr;
                @(posedge clk);
                #1 bus.reg_rdata = rom(a);
            end
        end
    end

    // UART transmitter: busy for TX_BUSY_CYCLES after tx_dv, then a one-cycle tx_done.
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.tx_dv === 1'b1) begin
                tx_busy = 1'b1;
                repeat (TX_BUSY_CYCLES - 1) @(posedge clk);
                #1;
                tx_busy     = 1'b0;
                bus.tx_done = 1'b1;
                @(posedge clk);
                #1 bus.tx_done = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        bus_ev_t    e;
        logic       prev_active;
        logic       in_tx;
        logic [7:0] held_byte;
        prev_active = 1'b0;
        in_tx       = 1'b0;
        held_byte   = 8'h00;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                in_tx = 1'b0;
            end else begin
                if (bus.reg_we === 1'b1) begin
                    n_we++;
                    check("reg_we_expected", 32'(bus_q.size() != 0), 1);
                    if (bus_q.size() != 0) begin
                        e = bus_q.pop_front();
                        check("we_kind", 32'(e.is_write), 1);
                        check("we_addr", bus.reg_addr, e.addr);
                        check("we_data", bus.reg_wdata, e.data);
                    end
                end
                if (bus.reg_rd === 1'b1) begin
                    n_rd++;
                    check("reg_rd_expected", 32'(bus_q.size() != 0), 1);
                    if (bus_q.size() != 0) begin
                        e = bus_q.pop_front();
                        check("rd_kind", 32'(e.is_write), 0);
                        check("rd_addr", bus.reg_addr, e.addr);
                    end
                end
                if (bus.tx_dv === 1'b1) begin
                    n_txdv++;
                    check("tx_dv_while_busy", prev_active, 0);
                    check("tx_dv_expected", 32'(tx_q.size() != 0), 1);
                    if (tx_q.size() != 0) check("tx_byte", bus.tx_byte, tx_q.pop_front());
                    held_byte = bus.tx_byte;
                    in_tx     = 1'b1;
                end
                if (bus.tx_done === 1'b1 && in_tx) begin
                    check("tx_byte_hold", bus.tx_byte, held_byte);
                    in_tx = 1'b0;
                end
                if (bus.cmd_error === 1'b1) begin
                    n_err++;
                    check("cmd_error_expected", 32'(err_q.size() != 0), 1);
                    if (err_q.size() != 0) void'(err_q.pop_front());
                end
            end
            prev_active = bus.tx_active;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.Rx_valid = 1'b1;
        @(negedge clk);
        bus.Rx_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int c = 0;
        while ((bus_q.size() + tx_q.size() + err_q.size()) != 0 && c < 500) begin
            @(negedge clk);
            c++;
        end
        repeat (TX_BUSY_CYCLES + 4) @(negedge clk);
        check(name, bus_q.size() + tx_q.size() + err_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_dv"},     bus.tx_dv,     0);
        check({tag, "_tx_byte"},   bus.tx_byte,   8'h00);
        check({tag, "_reg_addr"},  bus.reg_addr,  8'h00);
        check({tag, "_reg_wdata"}, bus.reg_wdata, 8'h00);
        check({tag, "_reg_we"},    bus.reg_we,    0);
        check({tag, "_reg_rd"},    bus.reg_rd,    0);
        check({tag, "_cmd_error"}, bus.cmd_error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0, rd0, tx0, err0, cycles;
        rst          = 1'b1;
        bus.Rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Write 0x12 <= 0xA5, reply 'K'.
        we0 = n_we; tx0 = n_txdv; err0 = n_err;
        bus_q.push_back('{1'b1, 8'h12, 8'hA5});
        tx_q.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h12); send_byte(8'hA5);
        drain("write_drained");
        check("write_we_count", n_we - we0, 1);
        check("write_tx_count", n_txdv - tx0, 1);
        check("write_err_count", n_err - err0, 0);

        // Read 0x12 -> 0x3C.
        rd0 = n_rd; tx0 = n_txdv;
        bus_q.push_back('{1'b0, 8'h12, 8'h00});
        tx_q.push_back(8'h3C);
        send_byte(8'h52); send_byte(8'h12);
        drain("read_drained");
        check("read_rd_count", n_rd - rd0, 1);
        check("read_tx_count", n_txdv - tx0, 1);

        // Bad opcode.
        we0 = n_we; rd0 = n_rd; err0 = n_err;
        err_q.push_back(1);
        tx_q.push_back(8'h3F);
        send_byte(8'h41);
        drain("badop_drained");
        check("badop_err_count", n_err - err0, 1);
        check("badop_bus_count", (n_we - we0) + (n_rd - rd0), 0);

        // Timeout waiting for the data byte.
        we0 = n_we; tx0 = n_txdv; err0 = n_err;
        err_q.push_back(1);
        send_byte(8'h57); send_byte(8'h20);
        cycles = 0;
        while (n_err == err0 && cycles < 300) begin
            @(negedge clk);
            #1 cycles++;
        end
        check("timeout_cycles", cycles, CLKS_PER_TIMEOUT);
        drain("timeout_drained");
        check("timeout_we_count", n_we - we0, 0);
        check("timeout_tx_count", n_txdv - tx0, 0);

        bus_q.push_back('{1'b0, 8'h20, 8'h00});
        tx_q.push_back(8'hC3);
        send_byte(8'h52); send_byte(8'h20);
        drain("after_timeout_read_drained");

        // Transmitter busy, then overrun byte during WAIT_TX.
        we0 = n_we; tx0 = n_txdv; err0 = n_err;
        hold_busy = 1'b1;
        bus_q.push_back('{1'b1, 8'h30, 8'h77});
        tx_q.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h30); send_byte(8'h77);
        repeat (20) @(negedge clk);
        check("busy_tx_withheld", n_txdv - tx0, 0);
        check("busy_we_count", n_we - we0, 1);
        err_q.push_back(1);
        @(posedge clk);
        #1 hold_busy = 1'b0;
        cycles = 0;
        while (n_txdv == tx0 && cycles < 50) begin
            @(negedge clk);
            #1 cycles++;
        end
        check("busy_tx_released", n_txdv - tx0, 1);
        send_byte(8'h55);
        drain("overrun_drained");
        check("overrun_err_count", n_err - err0, 1);
        check("overrun_we_count", n_we - we0, 1);
        check("overrun_tx_count", n_txdv - tx0, 1);

        // Reset in the middle of a write command.
        send_byte(8'h57); send_byte(8'h12);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        we0 = n_we;
        err_q.push_back(1);
        tx_q.push_back(8'h3F);
        send_byte(8'hA5);
        drain("midreset_drained");
        check("midreset_we_count", n_we - we0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Byte-level command responder on the far side of the UART link: consumes received bytes from the UART receiver, decodes a 3-byte write / 2-byte read command protocol, performs one access on a simple register bus, and returns a one-byte reply through the UART transmitter. It sits between the UART block's receive and transmit byte ports and the design's control and status registers, so a host PC can peek and poke FPGA registers over the serial port.

## Interface
- CLKS_PER_TIMEOUT, 5_000_000, inter-byte timeout in clk cycles (100 ms at 50 MHz); minimum 2.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- Rx_valid  in  1  one-cycle strobe: rx_data holds a new received byte.
- rx_data  in  8  received byte, valid when Rx_valid=1.
- tx_active  in  1  transmitter busy.
- tx_done  in  1  one-cycle strobe: transmitter finished the byte, stop bit included.
- tx_dv  out  1  one-cycle strobe: start transmitting tx_byte.
- tx_byte  out  8  reply byte; held stable from the tx_dv cycle until tx_done.
- reg_addr  out  8  register bus address.
- reg_wdata  out  8  register bus write data.
- reg_we  out  1  one-cycle write strobe.
- reg_rd  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data; sampled on the cycle after reg_rd.
- cmd_error  out  1  one-cycle strobe on timeout, bad opcode, or dropped byte.

## Operation
- Protocol:
  - Write command: 0x57 ('W'), address byte, data byte. Reply 0x4B ('K').
  - Read command: 0x52 ('R'), address byte. Reply is the register value.
  - Any other first byte: reply 0x3F ('?') and pulse cmd_error.
- States and transitions:
  - IDLE: on Rx_valid, 0x57 or 0x52 goes to GET_ADDR with the opcode latched. Any other byte latches reply 0x3F and goes to SEND.
  - GET_ADDR: on Rx_valid, latch reg_addr. A write opcode goes to GET_DATA; a read opcode goes to READ.
  - GET_DATA: on Rx_valid, latch reg_wdata and go to WRITE.
  - WRITE: drive reg_we=1 for exactly one cycle, latch reply 0x4B, go to SEND.
  - READ: drive reg_rd=1 for exactly one cycle, go to READ_CAP.
  - READ_CAP: latch reg_rdata into tx_byte, go to SEND.
  - SEND: wait until tx_active=0, then pulse tx_dv for one cycle and go to WAIT_TX.
  - WAIT_TX: on tx_done, go to IDLE.
- Timeout: a counter clears on entry to GET_ADDR or GET_DATA and on every Rx_valid. If it reaches CLKS_PER_TIMEOUT-1 while in GET_ADDR or GET_DATA:
  - return to IDLE;
  - pulse cmd_error;
  - send no reply and make no bus access.
- Dropped bytes: Rx_valid while in WRITE, READ, READ_CAP, SEND or WAIT_TX discards the byte and pulses cmd_error. The state is not changed.
- reg_addr and reg_wdata hold their last latched values between commands.
- Reset mid-operation: every state returns to IDLE immediately. Any pending bus access or reply is abandoned, with no tx_dv, reg_we or reg_rd after reset.

## Timing
- Reset values: tx_dv=0, tx_byte=0x00, reg_addr=0x00, reg_wdata=0x00, reg_we=0, reg_rd=0, cmd_error=0. State IDLE, timeout counter 0.
- All outputs are registered.
- Write command: reg_we asserts 2 cycles after the Rx_valid of the data byte (GET_DATA→WRITE, then registered strobe). tx_dv follows no earlier than 1 cycle after reg_we.
- Read command: reg_rd asserts 2 cycles after the Rx_valid of the address byte. reg_rdata is captured on the cycle after reg_rd. tx_dv asserts no earlier than 2 cycles after reg_rd.
- Bad opcode: tx_dv and cmd_error both assert no earlier than 1 cycle after the offending Rx_valid.
- Exactly one tx_dv per reply. tx_dv is never asserted while tx_active=1.
- Back-to-back commands: a new opcode byte is accepted on the first cycle back in IDLE, i.e. the cycle after tx_done.

## Test plan
- Write: send 0x57, 0x12, 0xA5. Required: one reg_we pulse with reg_addr=0x12 and reg_wdata=0xA5; then one tx_dv with tx_byte=0x4B; cmd_error never asserts.
- Read: send 0x52, 0x12 with the bus model returning 0x3C for address 0x12. Required: one reg_rd pulse with reg_addr=0x12, then tx_dv with tx_byte=0x3C.
- Bad opcode: send 0x41. Required: cmd_error pulse and tx_dv with tx_byte=0x3F; no reg_we or reg_rd.
- Timeout: with CLKS_PER_TIMEOUT=100, send 0x57, 0x20, then no data byte. Required: after 100 idle cycles, cmd_error pulses and the block returns to IDLE with no reg_we and no tx_dv. A following 0x52, 0x20 is then served normally.
- Busy and overrun: hold tx_active=1 after a write command. Required: tx_dv is withheld until tx_active falls. A byte 0x55 arriving in WAIT_TX pulses cmd_error and is not decoded.
- Reset mid-command: assert rst after 0x57, 0x12. Required: all outputs return to their reset values. A later 0xA5 is treated as a bad opcode, giving reply 0x3F and no write.
